// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command scheduler: FSM state encodings,
// requester identities and command field widths.
package sd_cmd_pkg;

  localparam int CMD_INDEX_W = 6;
  localparam int CMD_ARG_W   = 32;

  // One-hot scheduler states
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_ISSUE   = 6'b000010,
    ST_WAIT    = 6'b000100,
    ST_RECOVER = 6'b001000,
    ST_ABORT   = 6'b010000,
    ST_DONE    = 6'b100000
  } cmd_state_e;

  // Which requester owns the command currently in flight
  typedef enum logic {
    OWN_SW   = 1'b0,
    OWN_AUTO = 1'b1
  } cmd_owner_e;

  // The watchdog only runs while a command is being issued or awaited
  function automatic logic watchdogActive(input cmd_state_e s);
    return (s == ST_ISSUE) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Saturating cycle counter guarding a command transaction. It is cleared
// while no command is outstanding and counts every enabled cycle. expired_o
// rises on the cycle in which the number of enabled cycles, counting the
// current one, reaches WDOG_LIMIT.
module cmd_watchdog #(
  parameter int unsigned         WDOG_W     = 16,
  parameter logic [WDOG_W-1:0]   WDOG_LIMIT = '1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WDOG_W-1:0] LimitMinusOne = WDOG_LIMIT - WDOG_W'(1);

  logic [WDOG_W-1:0] count_q;
  logic [WDOG_W-1:0] count_d;

  // Next count: clear wins, otherwise increment and stick at the limit
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != WDOG_LIMIT)) begin
      count_d = count_q + WDOG_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && !clear_i && (count_q >= LimitMinusOne);

endmodule

// File: rtl/cmd_scheduler.sv
// Arbitrates software and auto-command requests onto the single CMD_master
// channel, retries CMD-line timeouts, aborts hung transactions and reports
// completion back to the requester that owned the command.
module cmd_scheduler
  import sd_cmd_pkg::*;
#(
  parameter int unsigned       MAX_RETRY  = 2,
  parameter int unsigned       WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(16'hFFFF)
) (
  input  logic                   CLK_host,
  input  logic                   reset,
  input  logic                   sw_req,
  input  logic [CMD_INDEX_W-1:0] sw_index,
  input  logic [CMD_ARG_W-1:0]   sw_arg,
  output logic                   sw_ack,
  output logic                   sw_done,
  output logic                   sw_err,
  input  logic                   auto_req,
  input  logic [CMD_INDEX_W-1:0] auto_index,
  input  logic [CMD_ARG_W-1:0]   auto_arg,
  output logic                   auto_ack,
  output logic                   auto_done,
  output logic                   auto_err,
  output logic [31:0]            rsp_status,
  output logic [1:0]             retry_count,
  output logic                   busy,
  output logic                   master_new_cmd,
  output logic [CMD_INDEX_W-1:0] master_cmd_index,
  output logic [CMD_ARG_W-1:0]   master_cmd_arg,
  output logic                   master_abort,
  input  logic                   master_cmd_busy,
  input  logic                   master_cmd_complete,
  input  logic                   master_timeout_error,
  input  logic [31:0]            master_response_status
);

  localparam logic [1:0] RetryMax = 2'(MAX_RETRY);

  cmd_state_e             state_q;
  cmd_owner_e             owner_q;
  logic [CMD_INDEX_W-1:0] index_q;
  logic [CMD_ARG_W-1:0]   arg_q;
  logic [1:0]             retry_q;
  logic                   timeoutSeen_q;
  logic [31:0]            rsp_q;
  logic                   busy_q;
  logic                   newCmd_q;
  logic                   abort_q;
  logic                   swAck_q;
  logic                   swDone_q;
  logic                   swErr_q;
  logic                   autoAck_q;
  logic                   autoDone_q;
  logic                   autoErr_q;

  logic wdogExpired;
  logic finishNow;
  logic finishErr;

  cmd_watchdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_watchdog (
    .clock_i   (CLK_host),
    .reset_i   (reset),
    .clear_i   ((state_q == ST_IDLE) || (state_q == ST_RECOVER)),
    .enable_i  (watchdogActive(state_q)),
    .expired_o (wdogExpired)
  );

  // Decide whether this cycle ends the transaction, and with what status
  always_comb begin
    finishNow = 1'b0;
    finishErr = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (!wdogExpired && master_cmd_complete) begin
          if (timeoutSeen_q || master_timeout_error) begin
            if (retry_q >= RetryMax) begin
              finishNow = 1'b1;
              finishErr = 1'b1;
            end
          end else begin
            finishNow = 1'b1;
          end
        end
      end
      ST_ABORT: begin
        finishNow = 1'b1;
        finishErr = 1'b1;
      end
      default: begin
        finishNow = 1'b0;
        finishErr = 1'b0;
      end
    endcase
  end

  // Scheduler FSM with all outputs registered alongside the state
  always_ff @(posedge CLK_host) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_SW;
      index_q       <= '0;
      arg_q         <= '0;
      retry_q       <= '0;
      timeoutSeen_q <= 1'b0;
      rsp_q         <= '0;
      busy_q        <= 1'b0;
      newCmd_q      <= 1'b0;
      abort_q       <= 1'b0;
      swAck_q       <= 1'b0;
      swDone_q      <= 1'b0;
      swErr_q       <= 1'b0;
      autoAck_q     <= 1'b0;
      autoDone_q    <= 1'b0;
      autoErr_q     <= 1'b0;
    end else begin
      swAck_q    <= 1'b0;
      autoAck_q  <= 1'b0;
      abort_q    <= 1'b0;
      swDone_q   <= finishNow && (owner_q == OWN_SW);
      swErr_q    <= finishNow && finishErr && (owner_q == OWN_SW);
      autoDone_q <= finishNow && (owner_q == OWN_AUTO);
      autoErr_q  <= finishNow && finishErr && (owner_q == OWN_AUTO);
      case (state_q)
        ST_IDLE: begin
          if (auto_req) begin
            owner_q       <= OWN_AUTO;
            index_q       <= auto_index;
            arg_q         <= auto_arg;
            autoAck_q     <= 1'b1;
            retry_q       <= '0;
            timeoutSeen_q <= 1'b0;
            newCmd_q      <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_ISSUE;
          end else if (sw_req) begin
            owner_q       <= OWN_SW;
            index_q       <= sw_index;
            arg_q         <= sw_arg;
            swAck_q       <= 1'b1;
            retry_q       <= '0;
            timeoutSeen_q <= 1'b0;
            newCmd_q      <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wdogExpired) begin
            newCmd_q <= 1'b0;
            abort_q  <= 1'b1;
            state_q  <= ST_ABORT;
          end else if (master_cmd_busy) begin
            newCmd_q <= 1'b0;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wdogExpired) begin
            abort_q <= 1'b1;
            state_q <= ST_ABORT;
          end else if (master_cmd_complete) begin
            if (timeoutSeen_q || master_timeout_error) begin
              if (retry_q < RetryMax) begin
                retry_q       <= retry_q + 2'd1;
                timeoutSeen_q <= 1'b1;
                state_q       <= ST_RECOVER;
              end else begin
                state_q <= ST_DONE;
              end
            end else begin
              rsp_q   <= master_response_status;
              state_q <= ST_DONE;
            end
          end else if (master_timeout_error) begin
            timeoutSeen_q <= 1'b1;
          end
        end
        ST_RECOVER: begin
          if (!master_cmd_busy) begin
            timeoutSeen_q <= 1'b0;
            newCmd_q      <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ABORT: begin
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          index_q <= '0;
          arg_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          newCmd_q <= 1'b0;
          index_q  <= '0;
          arg_q    <= '0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign sw_ack           = swAck_q;
  assign sw_done          = swDone_q;
  assign sw_err           = swErr_q;
  assign auto_ack         = autoAck_q;
  assign auto_done        = autoDone_q;
  assign auto_err         = autoErr_q;
  assign rsp_status       = rsp_q;
  assign retry_count      = retry_q;
  assign busy             = busy_q;
  assign master_new_cmd   = newCmd_q;
  assign master_cmd_index = index_q;
  assign master_cmd_arg   = arg_q;
  assign master_abort     = abort_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: a behavioural CMD_master responder,
// a completion scoreboard and directed scenarios for arbitration, retry,
// watchdog abort and mid-transaction reset.
module tb_cmd_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sw_req = 1'b0;
  logic [5:0]  sw_index = '0;
  logic [31:0] sw_arg = '0;
  logic        sw_ack, sw_done, sw_err;
  logic        auto_req = 1'b0;
  logic [5:0]  auto_index = '0;
  logic [31:0] auto_arg = '0;
  logic        auto_ack, auto_done, auto_err;
  logic [31:0] rsp_status;
  logic [1:0]  retry_count;
  logic        busy;
  logic        master_new_cmd;
  logic [5:0]  master_cmd_index;
  logic [31:0] master_cmd_arg;
  logic        master_abort;
  logic        master_cmd_busy = 1'b0;
  logic        master_cmd_complete = 1'b0;
  logic        master_timeout_error = 1'b0;
  logic [31:0] master_response_status = '0;

  cmd_scheduler #(
    .MAX_RETRY  (2),
    .WDOG_W     (16),
    .WDOG_LIMIT (16'd16)
  ) dut (
    .CLK_host               (clk),
    .reset                  (reset),
    .sw_req                 (sw_req),
    .sw_index               (sw_index),
    .sw_arg                 (sw_arg),
    .sw_ack                 (sw_ack),
    .sw_done                (sw_done),
    .sw_err                 (sw_err),
    .auto_req               (auto_req),
    .auto_index             (auto_index),
    .auto_arg               (auto_arg),
    .auto_ack               (auto_ack),
    .auto_done              (auto_done),
    .auto_err               (auto_err),
    .rsp_status             (rsp_status),
    .retry_count            (retry_count),
    .busy                   (busy),
    .master_new_cmd         (master_new_cmd),
    .master_cmd_index       (master_cmd_index),
    .master_cmd_arg         (master_cmd_arg),
    .master_abort           (master_abort),
    .master_cmd_busy        (master_cmd_busy),
    .master_cmd_complete    (master_cmd_complete),
    .master_timeout_error   (master_timeout_error),
    .master_response_status (master_response_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isAuto;
    bit          err;
    logic [31:0] rsp;
    logic [1:0]  retry;
  } expect_t;

  expect_t     sbQueue[$];
  int          checkCount = 0;
  int          errCount = 0;
  int          cycleCnt = 0;
  int          ackCycle = 0;
  int          issueCount = 0;
  int          doneCount = 0;
  logic        prevNewCmd = 1'b0;
  logic [31:0] lastRsp = '0;

  // CMD_master model controls
  bit          neverBusy = 1'b0;
  bit          stuckBusy = 1'b0;
  bit          timeoutEarly = 1'b0;
  int          timeoutAttempts = 0;
  int          attemptNo = 0;
  logic [31:0] rspValue = '0;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expectDone(input bit isAuto, input bit err,
                            input logic [31:0] rsp, input logic [1:0] retry);
    expect_t e;
    e.isAuto = isAuto;
    e.err    = err;
    e.rsp    = rsp;
    e.retry  = retry;
    sbQueue.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {sw_ack, sw_done, sw_err, auto_ack, auto_done,
                auto_err, busy, master_new_cmd, master_abort, retry_count}, 0);
    checkOutput({tag, "_index"}, master_cmd_index, 0);
    checkOutput({tag, "_arg"}, master_cmd_arg, 0);
    checkOutput({tag, "_rsp"}, rsp_status, 0);
  endtask

  // Raise one request, check the grant one cycle later, then drop it
  task automatic applyStimulus(input bit isAuto, input logic [5:0] idx,
                               input logic [31:0] arg);
    @(posedge clk); #1;
    if (isAuto) begin
      auto_req = 1'b1; auto_index = idx; auto_arg = arg;
    end else begin
      sw_req = 1'b1; sw_index = idx; sw_arg = arg;
    end
    @(negedge clk);
    @(negedge clk);
    ackCycle = cycleCnt;
    checkOutput("ack", isAuto ? auto_ack : sw_ack, 1);
    checkOutput("new_cmd", master_new_cmd, 1);
    checkOutput("cmd_index", master_cmd_index, idx);
    checkOutput("cmd_arg", master_cmd_arg, arg);
    @(posedge clk); #1;
    auto_req = 1'b0;
    sw_req = 1'b0;
  endtask

  // Wait (bounded) for a done pulse, then confirm the return to IDLE
  task automatic waitDone(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = sw_done | auto_done;
    end
    checkOutput({tag, "_done_seen"}, seen, 1);
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_idle_index"}, master_cmd_index, 0);
  endtask

  always @(posedge clk) cycleCnt++;

  // Behavioural CMD_master: busy one cycle after new_cmd, complete later
  initial begin
    bit doTimeout;
    forever begin
      @(negedge clk);
      if (master_new_cmd && !neverBusy && !reset) begin
        @(posedge clk); #1;
        master_cmd_busy = 1'b1;
        doTimeout = attemptNo < timeoutAttempts;
        attemptNo++;
        if (stuckBusy) begin
          while (stuckBusy) @(posedge clk);
          #1;
          master_cmd_busy = 1'b0;
        end else begin
          repeat (3) @(posedge clk);
          #1;
          master_timeout_error = doTimeout && timeoutEarly;
          @(posedge clk); #1;
          master_timeout_error = 1'b0;
          @(posedge clk); #1;
          master_cmd_complete    = 1'b1;
          master_timeout_error   = doTimeout && !timeoutEarly;
          master_response_status = rspValue;
          @(posedge clk); #1;
          master_cmd_complete  = 1'b0;
          master_timeout_error = 1'b0;
          master_cmd_busy      = 1'b0;
        end
      end
    end
  end

  // Scoreboard: compare each done pulse against the oldest expectation
  always @(negedge clk) begin
    expect_t e;
    if (!reset) begin
      if (master_new_cmd && !prevNewCmd) issueCount++;
      if (sw_done || auto_done) begin
        doneCount++;
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("done_owner", {sw_done, auto_done}, {!e.isAuto, e.isAuto});
          checkOutput("done_err", auto_done ? auto_err : sw_err, e.err);
          checkOutput("done_rsp", rsp_status, e.rsp);
          checkOutput("done_retry", retry_count, e.retry);
        end
      end
    end
    prevNewCmd = master_new_cmd;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int d;
    int startDone;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Plain software command
    $display("[TB] basic software command");
    issueCount = 0; attemptNo = 0; timeoutAttempts = 0;
    rspValue = 32'h0000_0900;
    expectDone(1'b0, 1'b0, 32'h0000_0900, 2'd0);
    lastRsp = 32'h0000_0900;
    applyStimulus(1'b0, 6'd17, 32'h0000_0200);
    waitDone("basic");
    checkOutput("basic_issues", issueCount, 1);

    // Simultaneous requests: auto wins, software follows 2 cycles after done
    $display("[TB] priority");
    issueCount = 0; attemptNo = 0;
    rspValue = 32'hAAAA_0001;
    expectDone(1'b1, 1'b0, 32'hAAAA_0001, 2'd0);
    expectDone(1'b0, 1'b0, 32'h0000_0B0B, 2'd0);
    @(posedge clk); #1;
    auto_req = 1'b1; auto_index = 6'd12; auto_arg = 32'h1234_0000;
    sw_req = 1'b1; sw_index = 6'd7; sw_arg = 32'h0000_0055;
    @(negedge clk);
    @(negedge clk);
    checkOutput("prio_auto_ack", auto_ack, 1);
    checkOutput("prio_sw_ack", sw_ack, 0);
    checkOutput("prio_index", master_cmd_index, 6'd12);
    @(posedge clk); #1;
    auto_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = auto_done;
    end
    checkOutput("prio_auto_done_seen", seen, 1);
    rspValue = 32'h0000_0B0B;
    @(negedge clk);
    checkOutput("prio_sw_ack_early", sw_ack, 0);
    @(negedge clk);
    checkOutput("prio_sw_ack", sw_ack, 1);
    checkOutput("prio_sw_index", master_cmd_index, 6'd7);
    @(posedge clk); #1;
    sw_req = 1'b0;
    waitDone("prio");
    lastRsp = 32'h0000_0B0B;

    // Every attempt times out: retries exhausted, response untouched
    $display("[TB] retry exhausted");
    issueCount = 0; attemptNo = 0; timeoutAttempts = 3; timeoutEarly = 1'b0;
    rspValue = 32'hDEAD_BEEF;
    expectDone(1'b0, 1'b1, lastRsp, 2'd2);
    applyStimulus(1'b0, 6'd18, 32'h0000_1000);
    waitDone("exhaust");
    checkOutput("exhaust_issues", issueCount, 3);

    // Early sticky timeout on first attempt, clean second attempt
    $display("[TB] retry then success");
    issueCount = 0; attemptNo = 0; timeoutAttempts = 1; timeoutEarly = 1'b1;
    rspValue = 32'h0000_0A5A;
    expectDone(1'b0, 1'b0, 32'h0000_0A5A, 2'd1);
    applyStimulus(1'b0, 6'd25, 32'h0000_0007);
    waitDone("retry1");
    checkOutput("retry1_issues", issueCount, 2);
    lastRsp = 32'h0000_0A5A;
    timeoutAttempts = 0; timeoutEarly = 1'b0;

    // Master never goes busy: watchdog abort
    $display("[TB] watchdog abort");
    issueCount = 0; neverBusy = 1'b1;
    expectDone(1'b0, 1'b1, lastRsp, 2'd0);
    applyStimulus(1'b0, 6'd3, 32'h0000_0033);
    seen = 1'b0;
    d = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = master_abort;
      d = cycleCnt - ackCycle;
    end
    checkOutput("abort_seen", seen, 1);
    checkOutput("abort_latency", d, 16);
    @(negedge clk);
    checkOutput("abort_width", master_abort, 0);
    checkOutput("abort_done", sw_done, 1);
    @(negedge clk);
    checkOutput("abort_idle", busy, 0);
    checkOutput("abort_issues", issueCount, 1);
    neverBusy = 1'b0;

    // Reset while waiting for the master
    $display("[TB] reset in WAIT");
    stuckBusy = 1'b1; attemptNo = 0;
    startDone = doneCount;
    applyStimulus(1'b0, 6'd9, 32'h0000_0099);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("wait_busy", busy, 1);
    checkOutput("wait_new_cmd", master_new_cmd, 0);
    @(negedge clk);
    checkAllZero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    stuckBusy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset_no_done", doneCount - startDone, 0);
    lastRsp = '0;

    // Fresh request after reset
    rspValue = 32'h0000_0077;
    expectDone(1'b0, 1'b0, 32'h0000_0077, 2'd0);
    applyStimulus(1'b0, 6'd5, 32'h0000_0009);
    waitDone("fresh");

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sbQueue.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
